// File: rtl/cache_control_2way_pkg.sv
// rtl/cache_control_2way_pkg.sv - shared types and helpers for the 2-way L1 cache controller
package cache_control_2way_pkg;

    localparam int CACHE_WAYS = 2;

    typedef logic [8:0]   cache_tag;
    typedef logic [2:0]   cache_index;
    typedef logic [3:0]   cache_offset;
    typedef logic [127:0] cache_line;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE
    } cache_state_t;

    // True when the way the LRU bit points at holds modified data that must be flushed first.
    function automatic logic victim_dirty(input logic lru, input logic valid0, input logic valid1,
                                          input logic dirty0, input logic dirty1);
        return lru ? (valid1 & dirty1) : (valid0 & dirty0);
    endfunction

endpackage

// File: rtl/cache_control_2way_if.sv
// rtl/cache_control_2way_if.sv - CPU, hit-detector, datapath and physical-memory signals of the controller
interface cache_control_2way_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_resp;
    logic                 hit;
    logic                 way0_hit;
    logic                 way1_hit;
    logic                 lru;
    logic                 valid0;
    logic                 valid1;
    logic                 dirty0;
    logic                 dirty1;
    logic                 pmem_resp;
    logic                 pmem_read;
    logic                 pmem_write;
    logic                 pmem_addr_sel;
    logic                 victim_way;
    logic                 load_way0;
    logic                 load_way1;
    logic                 data_sel;
    logic                 dirty_in;
    logic                 lru_load;
    logic                 lru_in;
    logic [CNT_WIDTH-1:0] hit_cnt;
    logic [CNT_WIDTH-1:0] miss_cnt;
    logic [CNT_WIDTH-1:0] wb_cnt;

    // Environment side: CPU, hit detector, array state and physical memory.
    modport master (
        output mem_read, mem_write, hit, way0_hit, way1_hit, lru,
               valid0, valid1, dirty0, dirty1, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, pmem_addr_sel, victim_way,
               load_way0, load_way1, data_sel, dirty_in, lru_load, lru_in,
               hit_cnt, miss_cnt, wb_cnt
    );

    // Controller side.
    modport slave (
        input  mem_read, mem_write, hit, way0_hit, way1_hit, lru,
               valid0, valid1, dirty0, dirty1, pmem_resp,
        output mem_resp, pmem_read, pmem_write, pmem_addr_sel, victim_way,
               load_way0, load_way1, data_sel, dirty_in, lru_load, lru_in,
               hit_cnt, miss_cnt, wb_cnt
    );

endinterface

// File: rtl/cache_control_2way_sat_counter.sv
// rtl/cache_control_2way_sat_counter.sv - saturating event counter
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Increment until all ones, then hold so the count never wraps.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_control_2way.sv
// rtl/cache_control_2way.sv - control FSM for the 2-way set-associative L1 cache
module cache_control_2way
    import cache_control_2way_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst,
    cache_control_2way_if.slave bus
);

    cache_state_t state_q;
    cache_state_t state_d;
    logic         victim_way_q;
    logic         victim_way_d;

    logic request;
    logic hit_way;
    logic needs_wb;
    logic hit_inc;
    logic miss_inc;
    logic wb_inc;

    assign request  = bus.mem_read | bus.mem_write;
    // Way 0 takes priority if the hit detector ever reports both ways.
    assign hit_way  = ~bus.way0_hit;
    assign needs_wb = victim_dirty(bus.lru, bus.valid0, bus.valid1, bus.dirty0, bus.dirty1);

    // State and victim registers; reset abandons any miss in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            victim_way_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            victim_way_q <= victim_way_d;
        end
    end

    // Next-state: a miss latches the LRU way as victim; memory transactions advance on pmem_resp.
    always_comb begin
        state_d      = state_q;
        victim_way_d = victim_way_q;
        case (state_q)
            S_IDLE: begin
                if (request && !bus.hit) begin
                    victim_way_d = bus.lru;
                    state_d      = needs_wb ? S_WRITEBACK : S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                // A request withdrawn during the flush needs no refill afterwards.
                if (bus.pmem_resp) begin
                    state_d = request ? S_ALLOCATE : S_IDLE;
                end
            end
            S_ALLOCATE: begin
                if (bus.pmem_resp) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Mealy outputs: everything idles low and is raised only by the current state and inputs.
    always_comb begin
        bus.mem_resp      = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.pmem_addr_sel = 1'b0;
        bus.load_way0     = 1'b0;
        bus.load_way1     = 1'b0;
        bus.data_sel      = 1'b0;
        bus.dirty_in      = 1'b0;
        bus.lru_load      = 1'b0;
        bus.lru_in        = 1'b0;
        hit_inc           = 1'b0;
        miss_inc          = 1'b0;
        wb_inc            = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (request && bus.hit) begin
                    bus.mem_resp = 1'b1;
                    bus.lru_load = 1'b1;
                    bus.lru_in   = ~hit_way;
                    hit_inc      = 1'b1;
                    if (bus.mem_write) begin
                        bus.load_way0 = ~hit_way;
                        bus.load_way1 = hit_way;
                        bus.data_sel  = 1'b0;
                        bus.dirty_in  = 1'b1;
                    end
                end else if (request) begin
                    miss_inc = 1'b1;
                    wb_inc   = needs_wb;
                end
            end
            S_WRITEBACK: begin
                bus.pmem_write    = 1'b1;
                bus.pmem_addr_sel = 1'b1;
            end
            S_ALLOCATE: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    bus.load_way0 = ~victim_way_q;
                    bus.load_way1 = victim_way_q;
                    bus.data_sel  = 1'b1;
                    bus.dirty_in  = 1'b0;
                end
            end
            default: begin
                bus.pmem_read = 1'b0;
            end
        endcase
    end

    assign bus.victim_way = victim_way_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (bus.hit_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (bus.miss_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (wb_inc),
        .count (bus.wb_cnt)
    );

endmodule

// File: tb/tb_cache_control_2way.sv
// tb/tb_cache_control_2way.sv - randomized self-checking bench against a behavioural cache model
module tb_cache_control_2way;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_control_2way_if #(.CNT_WIDTH(16)) bus ();
    cache_control_2way_if #(.CNT_WIDTH(4))  bus4 ();

    cache_control_2way #(.CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    cache_control_2way #(.CNT_WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    int total = 0;
    int bad   = 0;

    localparam int MAX16 = 65535;

    // Behavioural picture of the cache contents and perf counts.
    logic [8:0] tag_m   [2][8];
    logic       valid_m [2][8];
    logic       dirty_m [2][8];
    logic       lru_m   [8];
    int         hit_m;
    int         miss_m;
    int         wb_m;

    // Output bit order: mem_resp pmem_read pmem_write pmem_addr_sel load_way0 load_way1 data_sel dirty_in lru_load lru_in
    function automatic logic [9:0] obs16();
        return {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.pmem_addr_sel, bus.load_way0,
                bus.load_way1, bus.data_sel, bus.dirty_in, bus.lru_load, bus.lru_in};
    endfunction

    function automatic int sat(input int x, input int mx);
        return (x >= mx) ? mx : x + 1;
    endfunction

    function automatic logic model_hit(input logic [2:0] idx, input logic [8:0] tag);
        return (valid_m[0][idx] && tag_m[0][idx] == tag) || (valid_m[1][idx] && tag_m[1][idx] == tag);
    endfunction

    task automatic drive_lookup(input logic [2:0] idx, input logic [8:0] tag);
        logic h0;
        logic h1;
        h0 = valid_m[0][idx] && (tag_m[0][idx] == tag);
        h1 = valid_m[1][idx] && (tag_m[1][idx] == tag);
        bus.way0_hit = h0;
        bus.way1_hit = h1;
        bus.hit      = h0 | h1;
        bus.lru      = lru_m[idx];
        bus.valid0   = valid_m[0][idx];
        bus.valid1   = valid_m[1][idx];
        bus.dirty0   = dirty_m[0][idx];
        bus.dirty1   = dirty_m[1][idx];
    endtask

    task automatic clear_inputs();
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.hit = 1'b0; bus.way0_hit = 1'b0;
        bus.way1_hit = 1'b0; bus.lru = 1'b0; bus.valid0 = 1'b0; bus.valid1 = 1'b0;
        bus.dirty0 = 1'b0; bus.dirty1 = 1'b0; bus.pmem_resp = 1'b0;
        bus4.mem_read = 1'b0; bus4.mem_write = 1'b0; bus4.hit = 1'b0; bus4.way0_hit = 1'b0;
        bus4.way1_hit = 1'b0; bus4.lru = 1'b0; bus4.valid0 = 1'b0; bus4.valid1 = 1'b0;
        bus4.dirty0 = 1'b0; bus4.dirty1 = 1'b0; bus4.pmem_resp = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        hit_m = 0; miss_m = 0; wb_m = 0;
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < 8; s++) begin
                tag_m[w][s] = '0; valid_m[w][s] = 1'b0; dirty_m[w][s] = 1'b0;
            end
        end
        for (int s = 0; s < 8; s++) lru_m[s] = 1'b0;
    endtask

    // One complete CPU access; the model decides hit/miss, victim and writeback need.
    task automatic cpu_access(input logic wr, input logic [2:0] idx, input logic [8:0] tag,
                              input int wb_delay, input int rf_delay);
        logic [9:0] exp;
        logic       v;
        logic       wb;
        logic       hw;
        @(negedge clk);
        bus.mem_read  = ~wr;
        bus.mem_write = wr;
        bus.pmem_resp = 1'b0;
        drive_lookup(idx, tag);
        if (!model_hit(idx, tag)) begin
            v  = lru_m[idx];
            wb = valid_m[v][idx] && dirty_m[v][idx];
            #1;
            total++;
            if (obs16() !== 10'b0) begin
                bad++; $display("FAIL miss_lookup obs=%b exp=%b", obs16(), 10'b0);
            end
            miss_m = sat(miss_m, MAX16);
            if (wb) wb_m = sat(wb_m, MAX16);
            @(posedge clk);
            if (wb) begin
                for (int i = 0; i <= wb_delay; i++) begin
                    @(negedge clk);
                    bus.pmem_resp = (i == wb_delay);
                    #1;
                    if (i == 0) begin
                        total++;
                        if (bus.victim_way !== v) begin
                            bad++; $display("FAIL victim_wb obs=%b exp=%b", bus.victim_way, v);
                        end
                    end
                    exp = 10'b0011000000;
                    total++;
                    if (obs16() !== exp) begin
                        bad++; $display("FAIL writeback obs=%b exp=%b", obs16(), exp);
                    end
                    @(posedge clk);
                end
            end
            for (int i = 0; i <= rf_delay; i++) begin
                @(negedge clk);
                bus.pmem_resp = (i == rf_delay);
                #1;
                if (i == 0 && !wb) begin
                    total++;
                    if (bus.victim_way !== v) begin
                        bad++; $display("FAIL victim_alloc obs=%b exp=%b", bus.victim_way, v);
                    end
                end
                exp = 10'b0100000000;
                if (i == rf_delay) begin
                    exp[5] = ~v;
                    exp[4] = v;
                    exp[3] = 1'b1;
                end
                total++;
                if (obs16() !== exp) begin
                    bad++; $display("FAIL allocate obs=%b exp=%b", obs16(), exp);
                end
                @(posedge clk);
            end
            tag_m[v][idx] = tag; valid_m[v][idx] = 1'b1; dirty_m[v][idx] = 1'b0;
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            drive_lookup(idx, tag);
        end
        hw = !(valid_m[0][idx] && tag_m[0][idx] == tag);
        #1;
        exp    = 10'b0;
        exp[9] = 1'b1;
        exp[1] = 1'b1;
        exp[0] = ~hw;
        if (wr) begin
            exp[5] = ~hw;
            exp[4] = hw;
            exp[2] = 1'b1;
        end
        total++;
        if (obs16() !== exp) begin
            bad++; $display("FAIL hit_service obs=%b exp=%b", obs16(), exp);
        end
        hit_m = sat(hit_m, MAX16);
        lru_m[idx] = ~hw;
        if (wr) dirty_m[hw][idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        #1;
        total++;
        if (obs16() !== 10'b0) begin
            bad++; $display("FAIL idle_after obs=%b exp=%b", obs16(), 10'b0);
        end
        total++;
        if (bus.hit_cnt !== 16'(hit_m) || bus.miss_cnt !== 16'(miss_m) || bus.wb_cnt !== 16'(wb_m)) begin
            bad++;
            $display("FAIL counters obs=%0d/%0d/%0d exp=%0d/%0d/%0d", bus.hit_cnt, bus.miss_cnt,
                     bus.wb_cnt, hit_m, miss_m, wb_m);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if (obs16() !== 10'b0 || bus.victim_way !== 1'b0) begin
            bad++; $display("FAIL reset_outputs obs=%b victim=%b exp=0", obs16(), bus.victim_way);
        end
        total++;
        if (bus.hit_cnt !== 16'd0 || bus.miss_cnt !== 16'd0 || bus.wb_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_counters obs=%0d/%0d/%0d exp=0/0/0", bus.hit_cnt, bus.miss_cnt, bus.wb_cnt);
        end
    endtask

    task automatic test_read_hit_way1();
        do_reset();
        tag_m[1][2] = 9'h055; valid_m[1][2] = 1'b1;
        tag_m[0][2] = 9'h011; valid_m[0][2] = 1'b1;
        cpu_access(1'b0, 3'd2, 9'h055, 0, 0);
    endtask

    task automatic test_write_miss_dirty();
        do_reset();
        tag_m[0][4] = 9'h0a0; valid_m[0][4] = 1'b1; dirty_m[0][4] = 1'b1; lru_m[4] = 1'b0;
        cpu_access(1'b1, 3'd4, 9'h1c3, 5, 2);
    endtask

    task automatic test_read_miss_clean();
        do_reset();
        tag_m[1][6] = 9'h077; valid_m[1][6] = 1'b1; dirty_m[1][6] = 1'b0; lru_m[6] = 1'b1;
        cpu_access(1'b0, 3'd6, 9'h0ee, 0, 3);
    endtask

    task automatic test_dual_hit();
        do_reset();
        @(negedge clk);
        bus.mem_write = 1'b1; bus.hit = 1'b1; bus.way0_hit = 1'b1; bus.way1_hit = 1'b1;
        bus.valid0 = 1'b1; bus.valid1 = 1'b1;
        #1;
        total++;
        if (obs16() !== 10'b1000100111) begin
            bad++; $display("FAIL dual_hit obs=%b exp=%b", obs16(), 10'b1000100111);
        end
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_rst_mid_miss();
        do_reset();
        lru_m[3] = 1'b1;
        @(negedge clk);
        bus.mem_read = 1'b1;
        drive_lookup(3'd3, 9'h010);
        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (obs16() !== 10'b0100000000 || bus.victim_way !== 1'b1) begin
            bad++; $display("FAIL pre_rst_alloc obs=%b victim=%b exp=%b victim=1", obs16(), bus.victim_way, 10'b0100000000);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_read = 1'b0;
        #1;
        total++;
        if (obs16() !== 10'b0 || bus.victim_way !== 1'b0) begin
            bad++; $display("FAIL rst_mid_miss obs=%b victim=%b exp=0", obs16(), bus.victim_way);
        end
        total++;
        if (bus.hit_cnt !== 16'd0 || bus.miss_cnt !== 16'd0 || bus.wb_cnt !== 16'd0) begin
            bad++; $display("FAIL rst_counters obs=%0d/%0d/%0d exp=0/0/0", bus.hit_cnt, bus.miss_cnt, bus.wb_cnt);
        end
        @(negedge clk);
        bus.pmem_resp = 1'b1;
        #1;
        total++;
        if (obs16() !== 10'b0) begin
            bad++; $display("FAIL late_pmem_resp obs=%b exp=%b", obs16(), 10'b0);
        end
        @(posedge clk);
        @(negedge clk);
        bus.pmem_resp = 1'b0;
    endtask

    task automatic test_pmem_resp_idle();
        do_reset();
        tag_m[0][5] = 9'h033; valid_m[0][5] = 1'b1;
        @(negedge clk);
        bus.pmem_resp = 1'b1;
        drive_lookup(3'd5, 9'h033);
        #1;
        total++;
        if (obs16() !== 10'b0) begin
            bad++; $display("FAIL idle_pmem_resp obs=%b exp=%b", obs16(), 10'b0);
        end
        @(posedge clk);
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        #1;
        total++;
        if (obs16() !== 10'b0 || bus.hit_cnt !== 16'd0 || bus.miss_cnt !== 16'd0) begin
            bad++; $display("FAIL idle_after_resp obs=%b hit=%0d miss=%0d exp=0", obs16(), bus.hit_cnt, bus.miss_cnt);
        end
        cpu_access(1'b0, 3'd5, 9'h033, 0, 0);
    endtask

    task automatic test_saturation();
        int n4;
        do_reset();
        n4 = 0;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            bus4.mem_read = 1'b1; bus4.hit = 1'b1; bus4.way0_hit = 1'b1; bus4.valid0 = 1'b1;
            #1;
            total++;
            if (bus4.mem_resp !== 1'b1) begin
                bad++; $display("FAIL sat_resp obs=%b exp=1", bus4.mem_resp);
            end
            @(posedge clk);
            #1;
            n4 = sat(n4, 15);
            total++;
            if (bus4.hit_cnt !== 4'(n4)) begin
                bad++; $display("FAIL sat_hit_cnt obs=%0d exp=%0d", bus4.hit_cnt, n4);
            end
        end
        @(negedge clk);
        clear_inputs();
        @(posedge clk);
        #1;
        total++;
        if (bus4.hit_cnt !== 4'd15 || bus4.miss_cnt !== 4'd0) begin
            bad++; $display("FAIL sat_hold obs=%0d/%0d exp=15/0", bus4.hit_cnt, bus4.miss_cnt);
        end
    endtask

    task automatic test_random();
        logic       wr;
        logic [2:0] idx;
        logic [8:0] tag;
        do_reset();
        for (int k = 0; k < 60; k++) begin
            wr  = 1'($urandom_range(0, 1));
            idx = 3'($urandom_range(0, 7));
            tag = 9'($urandom_range(0, 3));
            cpu_access(wr, idx, tag, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_read_hit_way1();
        test_write_miss_dirty();
        test_read_miss_clean();
        test_dual_hit();
        test_rst_mid_miss();
        test_pmem_resp_idle();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
